axi_line_master: RTL and testbench

- Upstream neighbour of the SDRAM AXI slave. Converts the core/cache memory-side line requests (fill and writeback) into AXI4 INCR bursts on the AXI bus feeding the SDRAM controller.
- Handles one outstanding transaction at a time.
- Returns a full line plus an error flag to the requester.

---
 rtl/axi_line_master.sv | 161 ++++++++++++++++
 tb/tb_axi_line_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master.sv
// Line-request to AXI4 INCR burst master: one outstanding fill or
// writeback, full line and error flag returned on a single-cycle pulse.
module axi_line_master #(
  parameter int         BEATS  = 4,
  parameter int         DATA_W = 32,
  parameter logic [3:0] ID     = 4'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [31:0]             req_addr_i,
  input  logic [BEATS*DATA_W-1:0] req_wdata_i,
  output logic                    resp_valid_o,
  output logic [BEATS*DATA_W-1:0] resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_awaddr,
  output logic [3:0]              m_axi_awid,
  output logic [7:0]              m_axi_awlen,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_W-1:0]       m_axi_wdata,
  output logic [DATA_W/8-1:0]     m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  input  logic [3:0]              m_axi_bid,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [31:0]             m_axi_araddr,
  output logic [3:0]              m_axi_arid,
  output logic [7:0]              m_axi_arlen,
  output logic [1:0]              m_axi_arburst,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_W-1:0]       m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic [3:0]              m_axi_rid,
  input  logic                    m_axi_rlast
);

  localparam int IW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW  = IW + 1;
  localparam int OFF = $clog2(BEATS * DATA_W / 8);
  localparam logic [31:0] AMASK = ~((32'd1 << OFF) - 32'd1);

  typedef enum logic [2:0] {
    IDLE, AW, W, B, AR, R, DONE
  } state_t;

  state_t                        state_q;
  logic [CW-1:0]                 cnt_q;
  logic [31:0]                   addr_q;
  logic [BEATS-1:0][DATA_W-1:0]  line_q;
  logic [BEATS*DATA_W-1:0]       rdata_q;
  logic                          err_q;
  logic                          rerr_q;
  logic [IW-1:0]                 idx;
  logic                          w_last;
  logic                          r_bad;
  logic                          b_bad;

  assign idx    = cnt_q[IW-1:0];
  assign w_last = (cnt_q == CW'(BEATS - 1));
  assign b_bad  = (m_axi_bresp != 2'b00) | (m_axi_bid != ID);

  // Excess beats and a premature rlast both poison the line.
  always_comb begin
    r_bad = (m_axi_rresp != 2'b00) | (m_axi_rid != ID);
    r_bad = r_bad | (cnt_q >= CW'(BEATS));
    r_bad = r_bad | (m_axi_rlast & (cnt_q < CW'(BEATS - 1)));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid_i) begin
          addr_q <= req_addr_i & AMASK;
          err_q  <= 1'b0;
          cnt_q  <= '0;
          if (req_we_i) begin
            line_q  <= req_wdata_i;
            state_q <= AW;
          end else begin
            state_q <= AR;
          end
        end
        AW: if (m_axi_awready) state_q <= W;
        W: if (m_axi_wready) begin
          if (w_last) begin
            cnt_q   <= '0;
            state_q <= B;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        B: if (m_axi_bvalid) begin
          err_q   <= err_q | b_bad;
          state_q <= DONE;
        end
        AR: if (m_axi_arready) state_q <= R;
        R: if (m_axi_rvalid) begin
          if (cnt_q < CW'(BEATS)) line_q[idx] <= m_axi_rdata;
          err_q <= err_q | r_bad;
          if (m_axi_rlast) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else if (cnt_q != CW'(BEATS)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          rdata_q <= line_q;
          rerr_q  <= err_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign resp_valid_o  = (state_q == DONE);
  assign resp_rdata_o  = (state_q == DONE) ? line_q : rdata_q;
  assign resp_err_o    = (state_q == DONE) ? err_q : rerr_q;

  assign m_axi_awvalid = (state_q == AW);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = ID;
  assign m_axi_awlen   = 8'(BEATS - 1);
  assign m_axi_awburst = 2'b01;

  assign m_axi_wvalid  = (state_q == W);
  assign m_axi_wdata   = line_q[idx];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == W) & w_last;

  assign m_axi_bready  = (state_q == B);

  assign m_axi_arvalid = (state_q == AR);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = ID;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arburst = 2'b01;

  assign m_axi_rready  = (state_q == R);

endmodule

// File: tb/tb_axi_line_master.sv
// Randomised bench for axi_line_master: behavioural AXI slave plus
// a line-level reference of addresses, beats, data and error flag.
module tb_axi_line_master;
  localparam int         BEATS = 4;
  localparam int         DW    = 32;
  localparam logic [3:0] ID    = 4'h0;
  localparam int         LW    = BEATS * DW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [31:0]   req_addr_i = '0;
  logic [LW-1:0] req_wdata_i = '0;
  logic          resp_valid_o;
  logic [LW-1:0] resp_rdata_o;
  logic          resp_err_o;
  logic          m_axi_awvalid, m_axi_awready = 1'b0;
  logic [31:0]   m_axi_awaddr;
  logic [3:0]    m_axi_awid;
  logic [7:0]    m_axi_awlen;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_wvalid, m_axi_wready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_bvalid = 1'b0, m_axi_bready;
  logic [1:0]    m_axi_bresp = '0;
  logic [3:0]    m_axi_bid = '0;
  logic          m_axi_arvalid, m_axi_arready = 1'b0;
  logic [31:0]   m_axi_araddr;
  logic [3:0]    m_axi_arid;
  logic [7:0]    m_axi_arlen;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_rvalid = 1'b0, m_axi_rready;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic [3:0]    m_axi_rid = '0;
  logic          m_axi_rlast = 1'b0;

  axi_line_master #(.BEATS(BEATS), .DATA_W(DW), .ID(ID)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid),
    .m_axi_awlen(m_axi_awlen), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
    .m_axi_arlen(m_axi_arlen), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int acc_cyc = 0;
  logic [LW-1:0] last_rd = '0;
  logic          last_err = 1'b0;
  logic [DW-1:0] rwords [16];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return n[0];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic idle_axi();
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
    m_axi_bresp = 0; m_axi_rresp = 0;
    m_axi_bid = ID; m_axi_rid = ID;
  endtask

  // One line transaction against the slave model.  nr = read beats
  // returned; resp/idbad corrupt the first response; abort_w >= 0
  // pulls reset while W beat abort_w is on the bus.
  task automatic txn(input bit we, input logic [31:0] addr,
                     input logic [LW-1:0] wd, input int nr,
                     input logic [1:0] resp, input bit idbad,
                     input int mode, input int abort_w);
    logic [31:0] ea;
    bit eerr, drop, done, ar_done, b_done;
    int acc, wbeat, rbeat, nfill;
    ea = addr & ~32'((BEATS * DW / 8) - 1);
    eerr = (resp != 0) || idbad || (!we && nr != BEATS);
    nfill = (nr < BEATS) ? nr : BEATS;
    drop = 0; done = 0; ar_done = 0; b_done = 0;
    acc = 0; wbeat = 0; rbeat = 0;
    req_valid_i = 1; req_we_i = we;
    req_addr_i = addr; req_wdata_i = wd;
    for (int n = 0; n < 400 && !done; n++) begin
      if (drop) req_valid_i = 0;
      if (req_valid_i && req_ready_o) begin
        acc = n; drop = 1; acc_cyc = cyc;
        check("hold_err", 64'(resp_err_o), 64'(last_err));
        check("hold_rdata", 64'(resp_rdata_o), 64'(last_rd));
      end
      m_axi_bvalid = we && wbeat == BEATS && !b_done;
      m_axi_bresp = resp;
      m_axi_bid = idbad ? ~ID : ID;
      if (m_axi_bvalid && m_axi_bready) b_done = 1;
      m_axi_rvalid = ar_done && rbeat < nr && rdy(mode == 2 ? 2 : 0, n);
      m_axi_rdata = rwords[rbeat];
      m_axi_rlast = (rbeat == nr - 1);
      m_axi_rresp = (rbeat == 0) ? resp : 2'b00;
      m_axi_rid = (rbeat == 0 && idbad) ? ~ID : ID;
      if (m_axi_rvalid) begin
        check("rready", 64'(m_axi_rready), 64'd1);
        check("ar_in_r", 64'(m_axi_arvalid), 64'd0);
        rbeat++;
      end
      m_axi_awready = rdy(mode, n);
      if (m_axi_awvalid) begin
        check("aw_we", 64'(we), 64'd1);
        check("awaddr", 64'(m_axi_awaddr), 64'(ea));
        check("awlen", 64'(m_axi_awlen), 64'(BEATS - 1));
        check("awburst", 64'(m_axi_awburst), 64'd1);
        check("awid", 64'(m_axi_awid), 64'(ID));
      end
      m_axi_wready = rdy(mode, n + 1);
      if (m_axi_wvalid) begin
        if (wbeat == abort_w) begin
          #2 rst_i = 0;
          #1;
          check("rst_rdy", 64'(req_ready_o), 64'd1);
          check("rst_wv", 64'(m_axi_wvalid), 64'd0);
          check("rst_aw", 64'(m_axi_awvalid), 64'd0);
          check("rst_rv", 64'(resp_valid_o), 64'd0);
          check("rst_rd", 64'(resp_rdata_o), 64'd0);
          check("rst_err", 64'(resp_err_o), 64'd0);
          idle_axi();
          req_valid_i = 0;
          @(negedge clk_i) rst_i = 1;
          @(posedge clk_i); #1;
          check("rst_rel", 64'(req_ready_o), 64'd1);
          last_rd = '0; last_err = 0;
          return;
        end
        check("wbeat_ok", 64'(wbeat < BEATS), 64'd1);
        check("wdata", 64'(m_axi_wdata), 64'(wd[(wbeat % BEATS) * DW +: DW]));
        check("wlast", 64'(m_axi_wlast), 64'(wbeat == BEATS - 1));
        check("wstrb", 64'(m_axi_wstrb), 64'((1 << (DW / 8)) - 1));
        if (m_axi_wready) wbeat++;
      end
      m_axi_arready = rdy(mode, n);
      if (m_axi_arvalid) begin
        check("ar_fill", 64'(we), 64'd0);
        check("araddr", 64'(m_axi_araddr), 64'(ea));
        check("arlen", 64'(m_axi_arlen), 64'(BEATS - 1));
        check("arburst", 64'(m_axi_arburst), 64'd1);
        check("arid", 64'(m_axi_arid), 64'(ID));
        if (m_axi_arready) ar_done = 1;
      end
      if (resp_valid_o) begin
        done = 1;
        check("resp_err", 64'(resp_err_o), 64'(eerr));
        check("ar_in_done", 64'(m_axi_arvalid), 64'd0);
        if (!we)
          for (int i = 0; i < nfill; i++)
            check("rdata", 64'(resp_rdata_o[i * DW +: DW]), 64'(rwords[i]));
        if (mode == 0 && (we || nr == BEATS))
          check("latency", 64'(n - acc), 64'(we ? BEATS + 3 : BEATS + 2));
        last_rd = resp_rdata_o;
        last_err = resp_err_o;
      end
      @(posedge clk_i); #1;
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    idle_axi();
    check("pulse", 64'(resp_valid_o), 64'd0);
    check("idle_rdy", 64'(req_ready_o), 64'd1);
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) rwords[i] = $urandom;
  endtask

  initial begin
    logic [LW-1:0] wl;
    int a1;
    idle_axi();
    repeat (2) @(posedge clk_i);
    #1;
    check("r_rdy", 64'(req_ready_o), 64'd1);
    check("r_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                          m_axi_bready, m_axi_rready, resp_valid_o}), 64'd0);
    check("r_err", 64'(resp_err_o), 64'd0);
    check("r_rdata", 64'(resp_rdata_o), 64'd0);
    @(negedge clk_i) rst_i = 1;
    @(posedge clk_i); #1;

    rwords[0] = 32'h11; rwords[1] = 32'h22;
    rwords[2] = 32'h33; rwords[3] = 32'h44;
    txn(0, 32'h0000_1234, '0, BEATS, 2'b00, 0, 0, -1);
    check("tp1_line", 64'(resp_rdata_o[63:0]), 64'h00000022_00000011);

    wl = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    txn(1, 32'h0000_2000, wl, 0, 2'b00, 0, 1, -1);
    txn(1, 32'h0000_3008, wl, 0, 2'b10, 0, 0, -1);
    rand_words(BEATS);
    txn(0, 32'h0000_4000, '0, BEATS, 2'b00, 0, 0, -1);

    rand_words(BEATS);
    txn(0, 32'h0000_5000, '0, 2, 2'b00, 0, 0, -1);
    rand_words(BEATS);
    txn(0, 32'h0000_5010, '0, BEATS, 2'b00, 0, 0, -1);
    rand_words(BEATS + 2);
    txn(0, 32'h0000_6000, '0, BEATS + 2, 2'b00, 0, 0, -1);
    rand_words(BEATS);
    txn(0, 32'h0000_6100, '0, BEATS, 2'b00, 1, 0, -1);
    txn(1, 32'h0000_6200, wl, 0, 2'b00, 1, 0, -1);

    txn(1, 32'h0000_7000, wl, 0, 2'b00, 0, 1, 2);
    rand_words(BEATS);
    txn(0, 32'h0000_7040, '0, BEATS, 2'b00, 0, 0, -1);

    rand_words(BEATS);
    txn(0, 32'h0000_8000, '0, BEATS, 2'b00, 0, 0, -1);
    a1 = acc_cyc;
    rand_words(BEATS);
    txn(0, 32'h0000_8010, '0, BEATS, 2'b00, 0, 0, -1);
    check("b2b_gap", 64'(acc_cyc - a1), 64'(BEATS + 3));

    for (int t = 0; t < 16; t++) begin
      bit we;
      int nr;
      logic [1:0] rs;
      we = 1'($urandom_range(0, 1));
      nr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, BEATS + 2) : BEATS;
      rs = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wl = {$urandom, $urandom, $urandom, $urandom};
      rand_words(BEATS + 2);
      txn(we, $urandom, wl, nr, rs, ($urandom_range(0, 7) == 0),
          $urandom_range(0, 2), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
